// File: rtl/uart_rx_ctrl_if.sv
// rtl/uart_rx_ctrl_if.sv - receiver handshake and FIFO read stream bundle for uart_rx_ctrl
interface uart_rx_ctrl_if;
  logic [7:0] rx_data_i;
  logic       rx_ready_i;
  logic       rx_ack_o;
  logic [7:0] rd_data_o;
  logic       rd_valid_o;
  logic       rd_ready_i;

  // Controller side: acknowledges the receiver and sources the read stream
  modport master (
    input  rx_data_i, rx_ready_i, rd_ready_i,
    output rx_ack_o, rd_data_o, rd_valid_o
  );

  // Environment side: receiver plus downstream consumer
  modport slave (
    output rx_data_i, rx_ready_i, rd_ready_i,
    input  rx_ack_o, rd_data_o, rd_valid_o
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive controller: ack FSM, receive FIFO, idle-gated config apply (optional UART_RX_CTRL_OVERFLOW_COUNT_EN)
module uart_rx_ctrl #(
  parameter int CLOCK_DIVIDER_WIDTH = 16,
  parameter int DEFAULT_DIVIDER     = 87,
  parameter int FIFO_DEPTH          = 4
) (
  input  logic                           clock_i,
  input  logic                           reset_i,
  input  logic                           serial_i,
  input  logic                           cfg_write_i,
  input  logic [CLOCK_DIVIDER_WIDTH-1:0] cfg_divider_i,
  input  logic                           cfg_parity_bit_i,
  input  logic                           cfg_parity_even_i,
  output logic                           cfg_pending_o,
  output logic [CLOCK_DIVIDER_WIDTH-1:0] clock_divider_o,
  output logic                           parity_bit_o,
  output logic                           parity_even_o,
  uart_rx_ctrl_if.master                 bus,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_count_o,
  output logic                           overflow_o,
  input  logic                           overflow_clear_i,
  output logic [7:0]                     overflow_count_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
  localparam logic [3:0] IDLE_BITS_MAX = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACK,
    ST_RELEASE
  } ack_state_t;

  ack_state_t state_q;
  logic       rx_ack_q;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             overflow_q;

  logic [CLOCK_DIVIDER_WIDTH-1:0] pend_divider_q;
  logic                           pend_parity_bit_q;
  logic                           pend_parity_even_q;
  logic                           pending_q;
  logic [CLOCK_DIVIDER_WIDTH-1:0] divider_q;
  logic                           parity_bit_q;
  logic                           parity_even_q;

  logic [CLOCK_DIVIDER_WIDTH-1:0] bit_timer_q;
  logic [3:0]                     idle_bits_q;

  logic capture;
  logic pop;
  logic full;
  logic push;
  logic drop;
  logic cfg_accept;
  logic cfg_apply;
  logic bit_wrap;

  // A capture happens only from IDLE, so one rx_ready assertion yields one byte
  assign capture = (state_q == ST_IDLE) && bus.rx_ready_i;
  assign pop     = (count_q != '0) && bus.rd_ready_i;
  assign full    = (count_q == FULL_COUNT);
  // A pop on the same edge frees the slot the full FIFO needs
  assign push    = capture && (!full || pop);
  assign drop    = capture && full && !pop;

  assign cfg_accept = cfg_write_i && (cfg_divider_i >= CLOCK_DIVIDER_WIDTH'(2));
  assign cfg_apply  = pending_q && (idle_bits_q == IDLE_BITS_MAX);
  assign bit_wrap   = (bit_timer_q == divider_q - CLOCK_DIVIDER_WIDTH'(1));

  // Next occupancy from the push/pop pair
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Ack FSM: four-phase handshake with a one-cycle low gap between acks
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      rx_ack_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.rx_ready_i) begin
            rx_ack_q <= 1'b1;
            state_q  <= ST_ACK;
          end
        end
        ST_ACK: begin
          if (!bus.rx_ready_i) begin
            rx_ack_q <= 1'b0;
            state_q  <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          rx_ack_q <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: begin
          rx_ack_q <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  // FIFO storage; contents are masked by the count so no reset is needed
  always_ff @(posedge clock_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.rx_data_i;
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (overflow_clear_i) begin
        overflow_q <= 1'b0;
      end
    end
  end

`ifdef UART_RX_CTRL_OVERFLOW_COUNT_EN
  logic [7:0] ovf_count_q;

  // Saturating dropped-byte counter; a drop in the clearing cycle counts as the first
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      ovf_count_q <= 8'd0;
    end else if (drop) begin
      if (overflow_clear_i) begin
        ovf_count_q <= 8'd1;
      end else if (ovf_count_q != 8'hFF) begin
        ovf_count_q <= ovf_count_q + 8'd1;
      end
    end else if (overflow_clear_i) begin
      ovf_count_q <= 8'd0;
    end
  end

  assign overflow_count_o = ovf_count_q;
`else
  assign overflow_count_o = 8'd0;
`endif

  // Idle detector: counts whole bit times of continuous high line, saturating at 11
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      bit_timer_q <= '0;
      idle_bits_q <= 4'd0;
    end else if (!serial_i) begin
      bit_timer_q <= '0;
      idle_bits_q <= 4'd0;
    end else if (bit_wrap) begin
      bit_timer_q <= '0;
      if (idle_bits_q != IDLE_BITS_MAX) idle_bits_q <= idle_bits_q + 4'd1;
    end else begin
      bit_timer_q <= bit_timer_q + CLOCK_DIVIDER_WIDTH'(1);
    end
  end

  // Pending/applied configuration; a new write coinciding with an apply stays pending
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      pend_divider_q     <= CLOCK_DIVIDER_WIDTH'(DEFAULT_DIVIDER);
      pend_parity_bit_q  <= 1'b0;
      pend_parity_even_q <= 1'b0;
      pending_q          <= 1'b0;
      divider_q          <= CLOCK_DIVIDER_WIDTH'(DEFAULT_DIVIDER);
      parity_bit_q       <= 1'b0;
      parity_even_q      <= 1'b0;
    end else begin
      if (cfg_apply) begin
        divider_q     <= pend_divider_q;
        parity_bit_q  <= pend_parity_bit_q;
        parity_even_q <= pend_parity_even_q;
        pending_q     <= 1'b0;
      end
      if (cfg_accept) begin
        pend_divider_q     <= cfg_divider_i;
        pend_parity_bit_q  <= cfg_parity_bit_i;
        pend_parity_even_q <= cfg_parity_even_i;
        pending_q          <= 1'b1;
      end
    end
  end

  assign bus.rx_ack_o   = rx_ack_q;
  assign bus.rd_valid_o = (count_q != '0);
  assign bus.rd_data_o  = (count_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
  assign fifo_count_o   = count_q;
  assign overflow_o     = overflow_q;
  assign cfg_pending_o  = pending_q;
  assign clock_divider_o = divider_q;
  assign parity_bit_o   = parity_bit_q;
  assign parity_even_o  = parity_even_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;
  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        serial_i;
  logic        cfg_write_i;
  logic [15:0] cfg_divider_i;
  logic        cfg_parity_bit_i;
  logic        cfg_parity_even_i;
  logic        cfg_pending_o;
  logic [15:0] clock_divider_o;
  logic        parity_bit_o;
  logic        parity_even_o;
  logic [2:0]  fifo_count_o;
  logic        overflow_o;
  logic        overflow_clear_i;
  logic [7:0]  overflow_count_o;

  int checks = 0;
  int errors = 0;

`ifdef UART_RX_CTRL_OVERFLOW_COUNT_EN
  localparam logic [7:0] OVF_ONE = 8'd1;
`else
  localparam logic [7:0] OVF_ONE = 8'd0;
`endif

  uart_rx_ctrl_if bus ();

  uart_rx_ctrl dut (
    .clock_i          (clock_i),
    .reset_i          (reset_i),
    .serial_i         (serial_i),
    .cfg_write_i      (cfg_write_i),
    .cfg_divider_i    (cfg_divider_i),
    .cfg_parity_bit_i (cfg_parity_bit_i),
    .cfg_parity_even_i(cfg_parity_even_i),
    .cfg_pending_o    (cfg_pending_o),
    .clock_divider_o  (clock_divider_o),
    .parity_bit_o     (parity_bit_o),
    .parity_even_o    (parity_even_o),
    .bus              (bus.master),
    .fifo_count_o     (fifo_count_o),
    .overflow_o       (overflow_o),
    .overflow_clear_i (overflow_clear_i),
    .overflow_count_o (overflow_count_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic wait_ack();
    int n = 0;
    do begin
      tick();
      n++;
    end while (bus.rx_ack_o !== 1'b1 && n < 8);
    if (bus.rx_ack_o !== 1'b1) check("ack_timeout", {31'd0, bus.rx_ack_o}, 32'd1);
  endtask

  task automatic rx_send(input logic [7:0] b);
    bus.rx_data_i  = b;
    bus.rx_ready_i = 1'b1;
    wait_ack();
    bus.rx_ready_i = 1'b0;
    tick();
    tick();
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, {31'd0, bus.rd_valid_o}, 32'd1);
    check({tag, "_data"}, {24'd0, bus.rd_data_o}, {24'd0, exp});
    bus.rd_ready_i = 1'b1;
    tick();
    bus.rd_ready_i = 1'b0;
  endtask

  task automatic cfg_write(input logic [15:0] div, input logic pb, input logic pe);
    cfg_divider_i     = div;
    cfg_parity_bit_i  = pb;
    cfg_parity_even_i = pe;
    cfg_write_i       = 1'b1;
    tick();
    cfg_write_i = 1'b0;
  endtask

  task automatic do_reset();
    #2 reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    tick();
  endtask

  initial begin
    reset_i = 1'b1;
    serial_i = 1'b1;
    cfg_write_i = 1'b0;
    cfg_divider_i = 16'd0;
    cfg_parity_bit_i = 1'b0;
    cfg_parity_even_i = 1'b0;
    overflow_clear_i = 1'b0;
    bus.rx_data_i = 8'h00;
    bus.rx_ready_i = 1'b0;
    bus.rd_ready_i = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_ack", {31'd0, bus.rx_ack_o}, 32'd0);
    check("rst_valid", {31'd0, bus.rd_valid_o}, 32'd0);
    check("rst_data", {24'd0, bus.rd_data_o}, 32'd0);
    check("rst_count", {29'd0, fifo_count_o}, 32'd0);
    check("rst_ovf", {31'd0, overflow_o}, 32'd0);
    check("rst_ovfcnt", {24'd0, overflow_count_o}, 32'd0);
    check("rst_pend", {31'd0, cfg_pending_o}, 32'd0);
    check("rst_div", {16'd0, clock_divider_o}, 32'd87);
    check("rst_pb", {31'd0, parity_bit_o}, 32'd0);
    check("rst_pe", {31'd0, parity_even_o}, 32'd0);
    reset_i = 1'b0;
    tick();

    // Divider below 2 is ignored
    cfg_write(16'd1, 1'b1, 1'b1);
    tick();
    check("div1_pend", {31'd0, cfg_pending_o}, 32'd0);
    check("div1_div", {16'd0, clock_divider_o}, 32'd87);

    // Single byte handshake and ack low gap
    bus.rx_data_i = 8'hA5;
    bus.rx_ready_i = 1'b1;
    check("a5_ack_pre", {31'd0, bus.rx_ack_o}, 32'd0);
    tick();
    check("a5_ack", {31'd0, bus.rx_ack_o}, 32'd1);
    check("a5_valid", {31'd0, bus.rd_valid_o}, 32'd1);
    check("a5_data", {24'd0, bus.rd_data_o}, 32'hA5);
    tick();
    check("a5_ack_hold", {31'd0, bus.rx_ack_o}, 32'd1);
    check("a5_count_hold", {29'd0, fifo_count_o}, 32'd1);
    bus.rx_ready_i = 1'b0;
    tick();
    check("a5_ack_fall", {31'd0, bus.rx_ack_o}, 32'd0);
    bus.rx_data_i = 8'h3C;
    bus.rx_ready_i = 1'b1;
    tick();
    check("gap_ack_low", {31'd0, bus.rx_ack_o}, 32'd0);
    check("gap_count", {29'd0, fifo_count_o}, 32'd1);
    tick();
    check("second_ack", {31'd0, bus.rx_ack_o}, 32'd1);
    check("second_count", {29'd0, fifo_count_o}, 32'd2);
    bus.rx_ready_i = 1'b0;
    tick();
    tick();
    pop_check("pop_a5", 8'hA5);
    pop_check("pop_3c", 8'h3C);
    check("empty_valid", {31'd0, bus.rd_valid_o}, 32'd0);

    // Overflow with five pushes into a four-entry FIFO
    do_reset();
    for (int i = 1; i <= 5; i++) rx_send(8'(i));
    check("ovf_count", {29'd0, fifo_count_o}, 32'd4);
    check("ovf_flag", {31'd0, overflow_o}, 32'd1);
    check("ovf_cnt", {24'd0, overflow_count_o}, {24'd0, OVF_ONE});
    for (int i = 1; i <= 4; i++) pop_check("ovf_rd", 8'(i));
    check("ovf_empty", {31'd0, bus.rd_valid_o}, 32'd0);

    // Drop during clear keeps the flag; clear alone drops it
    for (int i = 0; i < 4; i++) rx_send(8'h50 + 8'(i));
    overflow_clear_i = 1'b1;
    bus.rx_data_i = 8'h99;
    bus.rx_ready_i = 1'b1;
    tick();
    overflow_clear_i = 1'b0;
    check("clr_prio_flag", {31'd0, overflow_o}, 32'd1);
    check("clr_prio_cnt", {24'd0, overflow_count_o}, {24'd0, OVF_ONE});
    bus.rx_ready_i = 1'b0;
    tick();
    tick();
    overflow_clear_i = 1'b1;
    tick();
    overflow_clear_i = 1'b0;
    check("clr_flag", {31'd0, overflow_o}, 32'd0);
    check("clr_cnt", {24'd0, overflow_count_o}, 32'd0);

    // Full FIFO with simultaneous capture and pop
    do_reset();
    for (int i = 0; i < 4; i++) rx_send(8'h11 + 8'(i));
    bus.rx_data_i = 8'h77;
    bus.rx_ready_i = 1'b1;
    bus.rd_ready_i = 1'b1;
    tick();
    bus.rd_ready_i = 1'b0;
    check("fullpop_count", {29'd0, fifo_count_o}, 32'd4);
    check("fullpop_ovf", {31'd0, overflow_o}, 32'd0);
    bus.rx_ready_i = 1'b0;
    tick();
    tick();
    pop_check("fullpop_rd0", 8'h12);
    pop_check("fullpop_rd1", 8'h13);
    pop_check("fullpop_rd2", 8'h14);
    pop_check("fullpop_rd3", 8'h77);

    // Config apply after 11 idle bit times at divider 87
    serial_i = 1'b0;
    cfg_write(16'd10, 1'b1, 1'b1);
    check("cfg_pend_set", {31'd0, cfg_pending_o}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      serial_i = ~serial_i;
      tick();
    end
    serial_i = 1'b0;
    tick();
    serial_i = 1'b1;
    repeat (957) tick();
    check("idle_pre_pend", {31'd0, cfg_pending_o}, 32'd1);
    check("idle_pre_div", {16'd0, clock_divider_o}, 32'd87);
    tick();
    check("idle_apply_pend", {31'd0, cfg_pending_o}, 32'd0);
    check("idle_apply_div", {16'd0, clock_divider_o}, 32'd10);
    check("idle_apply_pb", {31'd0, parity_bit_o}, 32'd1);
    check("idle_apply_pe", {31'd0, parity_even_o}, 32'd1);

    // Write on an already idle line applies one edge after latching
    cfg_write(16'd20, 1'b0, 1'b1);
    check("fast_pend", {31'd0, cfg_pending_o}, 32'd1);
    check("fast_div_old", {16'd0, clock_divider_o}, 32'd10);
    tick();
    check("fast_pend_clr", {31'd0, cfg_pending_o}, 32'd0);
    check("fast_div_new", {16'd0, clock_divider_o}, 32'd20);
    check("fast_pb", {31'd0, parity_bit_o}, 32'd0);

    // Later write overwrites the pending value
    serial_i = 1'b0;
    cfg_write(16'd30, 1'b1, 1'b0);
    cfg_write(16'd40, 1'b0, 1'b0);
    serial_i = 1'b1;
    begin
      int n = 0;
      while (cfg_pending_o === 1'b1 && n < 400) begin
        tick();
        n++;
      end
      check("ovw_timeout", {31'd0, cfg_pending_o}, 32'd0);
    end
    check("ovw_div", {16'd0, clock_divider_o}, 32'd40);

    // Asynchronous reset mid-operation
    serial_i = 1'b0;
    cfg_write(16'd50, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) rx_send(8'hC0 + 8'(i));
    bus.rx_data_i = 8'hEE;
    bus.rx_ready_i = 1'b1;
    tick();
    check("pre_rst_ack", {31'd0, bus.rx_ack_o}, 32'd1);
    check("pre_rst_count", {29'd0, fifo_count_o}, 32'd4);
    #2 reset_i = 1'b1;
    #1;
    check("arst_ack", {31'd0, bus.rx_ack_o}, 32'd0);
    check("arst_valid", {31'd0, bus.rd_valid_o}, 32'd0);
    check("arst_data", {24'd0, bus.rd_data_o}, 32'd0);
    check("arst_count", {29'd0, fifo_count_o}, 32'd0);
    check("arst_pend", {31'd0, cfg_pending_o}, 32'd0);
    check("arst_div", {16'd0, clock_divider_o}, 32'd87);
    check("arst_pb", {31'd0, parity_bit_o}, 32'd0);
    check("arst_pe", {31'd0, parity_even_o}, 32'd0);
    bus.rx_ready_i = 1'b0;
    tick();
    reset_i = 1'b0;
    tick();
    check("post_rst_valid", {31'd0, bus.rd_valid_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter CLOCK_DIVIDER_WIDTH, default 16: width of all divider values.
REQ-002 Parameter DEFAULT_DIVIDER, default 87: clock_divider_o value after reset.
REQ-003 Parameter FIFO_DEPTH, default 4: receive FIFO entries; power of 2, minimum 2.
REQ-004 clock_i  in  1  single clock; all logic on rising edge.
REQ-005 reset_i  in  1  reset, asynchronous, active-high.
REQ-006 serial_i  in  1  UART line, the same signal the receiver samples; used only for idle detection.
REQ-007 cfg_write_i  in  1  one-cycle request to load a new configuration.
REQ-008 cfg_divider_i / cfg_parity_bit_i / cfg_parity_even_i  in  CLOCK_DIVIDER_WIDTH/1/1  requested configuration.
REQ-009 cfg_pending_o  out  1  a configuration is latched and not yet applied.
REQ-010 clock_divider_o / parity_bit_o / parity_even_o  out  CLOCK_DIVIDER_WIDTH/1/1  applied configuration, driven to the receiver.
REQ-011 rx_data_i  in  8  receiver data; rx_ready_i  in  1  receiver holds a byte.
REQ-012 rx_ack_o  out  1  acknowledge to the receiver; acknowledge is edge-sensitive there.
REQ-013 rd_data_o  out  8  FIFO head; rd_valid_o  out  1  head valid; rd_ready_i  in  1  consumer accepts.
REQ-014 fifo_count_o  out  log2(FIFO_DEPTH)+1  occupied entries.
REQ-015 overflow_o  out  1  sticky dropped-byte flag; overflow_clear_i  in  1  clears it.
REQ-016 overflow_count_o  out  8  dropped-byte count (see Configuration).

Function
REQ-017 The ack FSM SHALL have three states: IDLE, ACK, RELEASE.
- IDLE with rx_ready_i=1: capture rx_data_i, assert rx_ack_o, go to ACK.
- ACK: hold rx_ack_o=1 until rx_ready_i=0, then drive rx_ack_o=0 and go to RELEASE.
- RELEASE: hold rx_ack_o=0 for exactly one cycle, then go to IDLE.
REQ-018 A capture SHALL write to the FIFO tail in the IDLE->ACK cycle; each rx_ready_i assertion SHALL produce exactly one capture.
REQ-019 When the FIFO is full at capture, the byte SHALL be dropped and overflow_o set; the receiver SHALL still be acknowledged.
REQ-020 A capture and a pop in the same cycle with the FIFO full SHALL be accepted, with count unchanged and no overflow.
REQ-021 rd_valid_o SHALL equal (fifo_count_o != 0); a pop occurs when rd_valid_o && rd_ready_i; rd_data_o SHALL show the head with zero-cycle read latency.
REQ-022 Pointers SHALL wrap modulo FIFO_DEPTH; ordering SHALL be strictly FIFO.
REQ-023 On the first edge after capture, rd_valid_o SHALL be 1 (one-cycle rx-to-valid latency).
REQ-024 If overflow_clear_i and an overflow occur in the same cycle, the overflow SHALL take priority and overflow_o SHALL stay 1.
REQ-025 cfg_write_i SHALL latch the cfg_* inputs into a pending register and set cfg_pending_o; a later write before apply SHALL overwrite the pending value.
REQ-026 A write with cfg_divider_i < 2 SHALL be ignored entirely.
REQ-027 Idle detector: a bit timer counts clock_divider_o clocks while serial_i=1; on each wrap an idle-bit counter increments, saturating at 11; any serial_i=0 clears both.
REQ-028 When cfg_pending_o=1 and the idle-bit counter is 11, the pending values SHALL be copied to the outputs on that edge and cfg_pending_o cleared; the idle counters are not reset by the apply.
REQ-029 A cfg_write_i arriving while the line is already idle for 11 bits SHALL apply on the next edge (latency 2 edges from the write).

Reset
REQ-030 On reset_i, asynchronously:
- rx_ack_o=0, rd_valid_o=0, rd_data_o=0, fifo_count_o=0
- overflow_o=0, overflow_count_o=0, cfg_pending_o=0
- clock_divider_o=DEFAULT_DIVIDER, parity_bit_o=0, parity_even_o=0
- FSM in IDLE, idle counters 0
REQ-031 Reset mid-operation SHALL discard FIFO contents and any pending configuration.

Configuration
REQ-032 With macro UART_RX_CTRL_OVERFLOW_COUNT_EN defined, overflow_count_o SHALL count dropped bytes, saturate at 255, and clear with overflow_clear_i; undefined, overflow_count_o SHALL be constant 0 and the counter SHALL be absent.

Verification
REQ-033 Receiver presents 0xA5 with ready held until ack -> rx_ack_o rises 1 cycle later; rd_data_o=0xA5 and rd_valid_o=1; ack low for 1 cycle before the next capture.
REQ-034 Push 0x01..0x05 with rd_ready_i=0, depth 4 -> fifo_count_o=4, overflow_o=1, overflow_count_o=1 (macro on) or 0 (macro off); reads return 0x01..0x04.
REQ-035 FIFO full, capture 0x77 with rd_ready_i=1 in the same cycle -> count stays 4, overflow_o=0, 0x77 is the last entry read.
REQ-036 cfg_write_i with divider 10 while serial_i toggles, then serial_i held high -> outputs change exactly 11*87 clocks after the last low; cfg_pending_o clears on that edge.
REQ-037 cfg_write_i with divider 1 -> cfg_pending_o stays 0 and clock_divider_o stays 87.
REQ-038 Reset asserted with 3 bytes buffered and ACK active -> all outputs take reset values immediately, without waiting for a clock edge.
